// File: rtl/m1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m1_pkg
// Brief    : Shared widths, fetch-entry type and PC helper for the M1 front end.
// Revision : 1.0
// ============================================================================
package m1_pkg;

  localparam int PC_W    = 15;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word PC is 15-bit modular, so 7FFF rolls over to 0000.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_m1.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue_m1
// Brief    : Synchronous FIFO of fetch entries with push/pop/flush and count.
// Revision : 1.0
// ============================================================================
module fetch_queue_m1
  import m1_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  fetch_entry_t               i_entry,
  input  logic                       i_pop,
  output fetch_entry_t               o_head,
  output logic                       o_valid,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  // A pop on an empty queue is ignored; a push into a full queue needs a same-cycle pop.
  assign w_do_pop  = i_pop && o_valid;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_unit_m1.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_m1
// Brief    : M1 fetch stage - PC generation, in-order imem requests, fetch queue.
// Revision : 1.0
// ============================================================================
module fetch_unit_m1
  import m1_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC  = 15'h0000,
  parameter int              FQ_DEPTH  = 4,
  parameter int              MAX_OUTST = 2
) (
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic               clk_en,
  input  logic               full_flush,
  input  logic               issue_inval,
  input  logic [PC_W-1:0]    pc_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               fq_valid,
  output logic [INSTR_W-1:0] fq_instr,
  output logic [PC_W-1:0]    fq_pc,
  input  logic               fq_ready
);

  localparam int FQ_CNT_W = $clog2(FQ_DEPTH + 1);
  localparam int OUT_W    = $clog2(MAX_OUTST + 1);

  logic [PC_W-1:0]     r_pc;
  logic [OUT_W-1:0]    r_outst;
  logic [OUT_W-1:0]    r_drop;

  logic                w_redirect;
  logic                w_redir_en;
  logic                w_fire;
  logic                w_rv;
  logic [31:0]         w_credit;

  logic                w_fq_push;
  logic                w_fq_pop;
  logic                w_fq_full;
  logic                w_fq_valid;
  logic [FQ_CNT_W-1:0] w_fq_count;
  fetch_entry_t        w_fq_in;
  fetch_entry_t        w_fq_head;

  fetch_entry_t        w_tag_in;
  fetch_entry_t        w_tag_head;
  logic                w_tag_valid;
  logic                w_tag_full;
  logic [OUT_W-1:0]    w_tag_count;
  logic                w_tag_unused;

  assign w_redirect = full_flush | issue_inval;
  assign w_redir_en = clk_en && w_redirect;
  assign w_rv       = clk_en && imem_rvalid;

  // Credit check counts in-flight requests against queue space, so every
  // response is guaranteed a slot and memory never sees backpressure.
  assign w_credit   = 32'(w_fq_count) + 32'(r_outst);
  assign imem_req   = async_rst_n && clk_en && !w_redirect &&
                      (r_outst < OUT_W'(MAX_OUTST)) && (w_credit < 32'(FQ_DEPTH));
  assign imem_addr  = r_pc;
  assign w_fire     = imem_req && imem_gnt;

  // Responses still owed to a pre-redirect stream are consumed but not queued.
  assign w_fq_push  = w_rv && !w_redir_en && (r_drop == '0);
  assign w_fq_pop   = clk_en && fq_ready;
  assign w_fq_in    = '{pc: w_tag_head.pc, instr: imem_rdata};
  assign w_tag_in   = '{pc: r_pc, instr: '0};

  assign fq_valid   = w_fq_valid;
  assign fq_instr   = w_fq_head.instr;
  assign fq_pc      = w_fq_head.pc;

  assign w_tag_unused = ^{w_tag_head.instr, w_tag_valid, w_tag_full, w_tag_count};

  fetch_queue_m1 #(
    .DEPTH   (FQ_DEPTH)
  ) u_fq (
    .clk     (clk),
    .rst_n   (async_rst_n),
    .i_flush (w_redir_en),
    .i_push  (w_fq_push),
    .i_entry (w_fq_in),
    .i_pop   (w_fq_pop),
    .o_head  (w_fq_head),
    .o_valid (w_fq_valid),
    .o_full  (w_fq_full),
    .o_count (w_fq_count)
  );

  // Tag FIFO is never flushed: each response, kept or dropped, retires one tag.
  fetch_queue_m1 #(
    .DEPTH   (MAX_OUTST)
  ) u_tag (
    .clk     (clk),
    .rst_n   (async_rst_n),
    .i_flush (1'b0),
    .i_push  (w_fire),
    .i_entry (w_tag_in),
    .i_pop   (w_rv),
    .o_head  (w_tag_head),
    .o_valid (w_tag_valid),
    .o_full  (w_tag_full),
    .o_count (w_tag_count)
  );

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_pc    <= RESET_PC;
      r_outst <= '0;
      r_drop  <= '0;
    end else if (clk_en) begin
      if (w_redirect) begin
        r_pc    <= pc_target;
        r_outst <= r_outst - OUT_W'(w_rv);
        r_drop  <= r_outst - OUT_W'(w_rv);
      end else begin
        if (w_fire) begin
          r_pc <= pc_inc(r_pc);
        end
        r_outst <= r_outst + OUT_W'(w_fire) - OUT_W'(w_rv);
        if (w_rv && (r_drop != '0)) begin
          r_drop <= r_drop - OUT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit_m1.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit_m1
// Brief    : Directed self-checking bench for fetch_unit_m1 with in-order imem model.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit_m1;
  import m1_pkg::*;

  logic        clk = 1'b0;
  logic        async_rst_n = 1'b1;
  logic        clk_en = 1'b0;
  logic        full_flush = 1'b0;
  logic        issue_inval = 1'b0;
  logic [14:0] pc_target = '0;
  logic        imem_req;
  logic [14:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        fq_valid;
  logic [15:0] fq_instr;
  logic [14:0] fq_pc;
  logic        fq_ready = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int lat = 1;
  logic [14:0] pend_addr[$];
  int          pend_due[$];
  logic [14:0] fire_log[$];
  logic [14:0] pop_log[$];

  always #5 clk = ~clk;

  fetch_unit_m1 #(
    .RESET_PC   (15'h0000),
    .FQ_DEPTH   (4),
    .MAX_OUTST  (2)
  ) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .full_flush  (full_flush),
    .issue_inval (issue_inval),
    .pc_target   (pc_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .fq_valid    (fq_valid),
    .fq_instr    (fq_instr),
    .fq_pc       (fq_pc),
    .fq_ready    (fq_ready)
  );

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    return {1'b1, a} ^ 16'hA5C3;
  endfunction

  // One clock: drive this cycle's response, sample at negedge, return at posedge+1.
  task automatic tick();
    if (clk_en && async_rst_n && (pend_addr.size() > 0) && (pend_due[0] <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    @(negedge clk);
    if (imem_req && imem_gnt) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      fire_log.push_back(imem_addr);
    end
    if (fq_valid && fq_ready && clk_en && async_rst_n && !full_flush && !issue_inval) begin
      pop_log.push_back(fq_pc);
      vectors++;
      if (fq_instr !== mem_word(fq_pc)) begin
        miscompares++;
        $display("FAIL scoreboard pc=%h: got instr %h, want %h", fq_pc, fq_instr, mem_word(fq_pc));
      end
    end
    vectors += 2;
    if (dut.r_outst > 2'd2) begin
      miscompares++;
      $display("FAIL outst_bound: got %0d, want <= 2", dut.r_outst);
    end
    if (dut.w_fq_push && dut.w_fq_full && !dut.w_fq_pop) begin
      miscompares++;
      $display("FAIL push_when_full: got push=1 full=1 pop=0, want no push");
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    clk_en = 1'b1; imem_gnt = 1'b1; fq_ready = 1'b1;
    #1 async_rst_n = 1'b0;
    tick(); tick();
    vectors += 4;
    if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", imem_req); end
    if (fq_valid !== 1'b0) begin miscompares++; $display("FAIL reset_fq_valid: got %b want 0", fq_valid); end
    if (fq_instr !== 16'h0) begin miscompares++; $display("FAIL reset_fq_instr: got %h want 0000", fq_instr); end
    if (fq_pc !== 15'h0) begin miscompares++; $display("FAIL reset_fq_pc: got %h want 0000", fq_pc); end
  endtask

  task automatic test_stream();
    lat = 1;
    fire_log.delete(); pop_log.delete();
    async_rst_n = 1'b1;
    #1;
    vectors += 2;
    if (imem_req !== 1'b1) begin miscompares++; $display("FAIL stream_first_req: got %b want 1", imem_req); end
    if (imem_addr !== 15'h0) begin miscompares++; $display("FAIL stream_first_addr: got %h want 0000", imem_addr); end
    repeat (12) tick();
    vectors += 2;
    if (fire_log.size() != 12) begin miscompares++; $display("FAIL stream_fires: got %0d want 12", fire_log.size()); end
    if (pop_log.size() != 10) begin miscompares++; $display("FAIL stream_pops: got %0d want 10", pop_log.size()); end
    foreach (fire_log[i]) begin
      vectors++;
      if (fire_log[i] !== 15'(i)) begin miscompares++; $display("FAIL stream_addr[%0d]: got %h want %h", i, fire_log[i], 15'(i)); end
    end
  endtask

  task automatic test_backpressure();
    fq_ready = 1'b0;
    fire_log.delete();
    repeat (10) tick();
    vectors += 6;
    if (fire_log.size() != 2) begin miscompares++; $display("FAIL bp_fires: got %0d want 2", fire_log.size()); end
    else if (fire_log[0] !== 15'd12 || fire_log[1] !== 15'd13) begin
      miscompares++; $display("FAIL bp_fire_addrs: got %h,%h want 000c,000d", fire_log[0], fire_log[1]);
    end
    if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_stalled: got %b want 0", imem_req); end
    if (fq_valid !== 1'b1) begin miscompares++; $display("FAIL bp_fq_valid: got %b want 1", fq_valid); end
    if (fq_pc !== 15'd10) begin miscompares++; $display("FAIL bp_head_pc: got %h want 000a", fq_pc); end
    if (pop_log.size() != 10) begin miscompares++; $display("FAIL bp_no_pops: got %0d want 10", pop_log.size()); end
    fq_ready = 1'b1;
    repeat (8) tick();
    vectors++;
    if (pop_log.size() != 18) begin miscompares++; $display("FAIL bp_drain_count: got %0d want 18", pop_log.size()); end
    foreach (pop_log[i]) begin
      vectors++;
      if (pop_log[i] !== 15'(i)) begin miscompares++; $display("FAIL bp_order[%0d]: got %h want %h", i, pop_log[i], 15'(i)); end
    end
  endtask

  task automatic test_redirect_inval();
    bit found = 1'b0;
    lat = 3; fq_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (pend_addr.size() == 2 && pend_due[0] > cyc) begin found = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL inval_setup_timeout: got no 2-outstanding window, want one"); end
    issue_inval = 1'b1; pc_target = 15'h0123;
    #1;
    vectors++;
    if (imem_req !== 1'b0) begin miscompares++; $display("FAIL inval_req_blocked: got %b want 0", imem_req); end
    tick();
    issue_inval = 1'b0;
    fire_log.delete(); pop_log.delete();
    #1;
    vectors += 3;
    if (imem_addr !== 15'h0123) begin miscompares++; $display("FAIL inval_addr: got %h want 0123", imem_addr); end
    if (dut.r_drop !== 2'd2) begin miscompares++; $display("FAIL inval_drop: got %0d want 2", dut.r_drop); end
    if (fq_valid !== 1'b0) begin miscompares++; $display("FAIL inval_fq_cleared: got %b want 0", fq_valid); end
    repeat (14) tick();
    vectors += 2;
    if (fire_log.size() < 1 || fire_log[0] !== 15'h0123) begin
      miscompares++; $display("FAIL inval_first_fire: got size %0d, want first addr 0123", fire_log.size());
    end
    if (pop_log.size() < 2 || pop_log[0] !== 15'h0123 || pop_log[1] !== 15'h0124) begin
      miscompares++; $display("FAIL inval_first_pops: got size %0d, want 0123,0124", pop_log.size());
    end
  endtask

  task automatic test_flush_rvalid();
    bit found = 1'b0;
    lat = 3; fq_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (pend_addr.size() == 2 && pend_due[0] <= cyc && fq_valid) begin found = 1'b1; break; end
      tick();
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL flush_setup_timeout: got no window, want outst=2 with rvalid"); end
    full_flush = 1'b1; pc_target = 15'h0456;
    tick();
    full_flush = 1'b0;
    fire_log.delete(); pop_log.delete();
    #1;
    vectors += 4;
    if (fq_valid !== 1'b0) begin miscompares++; $display("FAIL flush_fq_empty: got %b want 0", fq_valid); end
    if (imem_addr !== 15'h0456) begin miscompares++; $display("FAIL flush_addr: got %h want 0456", imem_addr); end
    if (dut.r_drop !== 2'd1) begin miscompares++; $display("FAIL flush_drop: got %0d want 1", dut.r_drop); end
    if (imem_req !== 1'b1) begin miscompares++; $display("FAIL flush_req: got %b want 1", imem_req); end
    fq_ready = 1'b1;
    repeat (12) tick();
    vectors += 2;
    if (fire_log.size() < 1 || fire_log[0] !== 15'h0456) begin
      miscompares++; $display("FAIL flush_first_fire: got size %0d, want first addr 0456", fire_log.size());
    end
    if (pop_log.size() < 1 || pop_log[0] !== 15'h0456) begin
      miscompares++; $display("FAIL flush_first_pop: got size %0d, want first pc 0456", pop_log.size());
    end
  endtask

  task automatic test_wrap_clk_en();
    logic [14:0] exp_pc;
    lat = 1; fq_ready = 1'b1;
    full_flush = 1'b1; issue_inval = 1'b1; pc_target = 15'h7FFE;
    tick();
    full_flush = 1'b0; issue_inval = 1'b0;
    fire_log.delete(); pop_log.delete();
    repeat (4) tick();
    clk_en = 1'b0;
    repeat (3) begin
      #1;
      vectors++;
      if (imem_req !== 1'b0) begin miscompares++; $display("FAIL clken_req: got %b want 0", imem_req); end
      tick();
    end
    clk_en = 1'b1;
    repeat (8) tick();
    vectors += 2;
    if (fire_log.size() < 4) begin miscompares++; $display("FAIL wrap_fires: got %0d want >= 4", fire_log.size()); end
    if (pop_log.size() < 4) begin miscompares++; $display("FAIL wrap_pops: got %0d want >= 4", pop_log.size()); end
    foreach (fire_log[i]) begin
      exp_pc = 15'h7FFE + 15'(i);
      vectors++;
      if (fire_log[i] !== exp_pc) begin miscompares++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, fire_log[i], exp_pc); end
    end
    foreach (pop_log[i]) begin
      exp_pc = 15'h7FFE + 15'(i);
      vectors++;
      if (pop_log[i] !== exp_pc) begin miscompares++; $display("FAIL wrap_pop[%0d]: got %h want %h", i, pop_log[i], exp_pc); end
    end
  endtask

  task automatic test_reset_mid();
    repeat (3) tick();
    #2 async_rst_n = 1'b0;
    #1;
    vectors += 4;
    if (imem_req !== 1'b0) begin miscompares++; $display("FAIL midrst_req: got %b want 0", imem_req); end
    if (fq_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_fq_valid: got %b want 0", fq_valid); end
    if (fq_pc !== 15'h0) begin miscompares++; $display("FAIL midrst_fq_pc: got %h want 0000", fq_pc); end
    if (fq_instr !== 16'h0) begin miscompares++; $display("FAIL midrst_fq_instr: got %h want 0000", fq_instr); end
    pend_addr.delete(); pend_due.delete();
    imem_rvalid = 1'b0; imem_rdata = '0;
    @(posedge clk); #1; cyc++;
    tick();
    async_rst_n = 1'b1;
    fire_log.delete(); pop_log.delete();
    #1;
    vectors += 2;
    if (imem_addr !== 15'h0) begin miscompares++; $display("FAIL midrst_restart_addr: got %h want 0000", imem_addr); end
    if (imem_req !== 1'b1) begin miscompares++; $display("FAIL midrst_restart_req: got %b want 1", imem_req); end
    repeat (6) tick();
    vectors++;
    if (pop_log.size() < 2 || pop_log[0] !== 15'h0 || pop_log[1] !== 15'h1) begin
      miscompares++; $display("FAIL midrst_pops: got size %0d, want 0000,0001 first", pop_log.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inval();
    test_flush_rvalid();
    test_wrap_clk_en();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
